// File: rtl/demux2_scheduler_pkg.sv
// Shared encodings and the burst-boundary routing rule for the 2-way demux scheduler.
package demux2_scheduler_pkg;

  typedef enum logic [1:0] {
    MODE_ALT   = 2'b00,
    MODE_FIX_B = 2'b01,
    MODE_FIX_C = 2'b10,
    MODE_SKIP  = 2'b11
  } mode_t;

  typedef enum logic {
    SEND_B = 1'b0,
    SEND_C = 1'b1
  } state_t;

  // Skip mode stays put only when the current consumer is ready and the other one is stalled.
  function automatic state_t boundary_next(input state_t cur, input mode_t m,
                                           input logic ready_b, input logic ready_c);
    logic   ready_cur;
    logic   ready_oth;
    state_t toggled;
    ready_cur = (cur == SEND_B) ? ready_b : ready_c;
    ready_oth = (cur == SEND_B) ? ready_c : ready_b;
    toggled   = (cur == SEND_B) ? SEND_C : SEND_B;
    case (m)
      MODE_ALT:   boundary_next = toggled;
      MODE_FIX_B: boundary_next = SEND_B;
      MODE_FIX_C: boundary_next = SEND_C;
      default:    boundary_next = (!ready_oth && ready_cur) ? cur : toggled;
    endcase
  endfunction

endpackage

// File: rtl/DeMultiplexer2ver.sv
// Combinational 2-way demultiplexer: Select=0 routes A to B, Select=1 routes A to C.
module DeMultiplexer2ver #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] A,
  input  logic             Select,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C
);

  assign B = Select ? '0 : A;
  assign C = Select ? A : '0;

endmodule

// File: rtl/demux2_hold_reg.sv
// One-deep holding register for the demux scheduler: captures a word with its route and
// releases it when the selected consumer takes it, allowing load and drain in the same cycle.
module demux2_hold_reg #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             in_valid,
  input  logic             target,
  input  logic             ready_b,
  input  logic             ready_c,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             sel,
  output logic             in_ready,
  output logic             accept
);

  logic drain;

  assign drain    = valid & (sel ? ready_c : ready_b);
  assign in_ready = ~rst & (~valid | drain);
  assign accept   = in_valid & in_ready;

  // A stalled word keeps data and sel untouched until its consumer accepts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
      sel   <= 1'b0;
    end else if (accept) begin
      data  <= din;
      valid <= 1'b1;
      sel   <= target;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux2_scheduler.sv
// Burst scheduler for the 2-way demux: steers BURST_LEN-word bursts of the input stream to
// output B or C according to the sampled mode, with per-output backpressure.
module demux2_scheduler
  import demux2_scheduler_pkg::*;
#(
  parameter int WIDTH     = 2,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  output logic             Select,
  output logic [WIDTH-1:0] outB,
  output logic             outB_valid,
  input  logic             outB_ready,
  output logic [WIDTH-1:0] outC,
  output logic             outC_valid,
  input  logic             outC_ready,
  output logic [CNT_W-1:0] burst_cnt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);

  state_t           state;
  mode_t            mode_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             sel_q;
  logic             accept;

  demux2_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .din      (A_in),
    .in_valid (in_valid),
    .target   (state == SEND_C),
    .ready_b  (outB_ready),
    .ready_c  (outC_ready),
    .data     (data_q),
    .valid    (valid_q),
    .sel      (sel_q),
    .in_ready (in_ready),
    .accept   (accept)
  );

  DeMultiplexer2ver #(.WIDTH(WIDTH)) u_demux (
    .A      (data_q),
    .Select (sel_q),
    .B      (outB),
    .C      (outC)
  );

  assign Select     = sel_q;
  assign outB_valid = valid_q & ~sel_q;
  assign outC_valid = valid_q & sel_q;

  // Mode is only picked up between bursts on an idle cycle, so a burst is never split.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEND_B;
      burst_cnt <= '0;
      mode_q    <= MODE_ALT;
    end else if (accept) begin
      if (burst_cnt == LAST) begin
        burst_cnt <= '0;
        state     <= boundary_next(state, mode_q, outB_ready, outC_ready);
      end else begin
        burst_cnt <= burst_cnt + CNT_W'(1);
      end
    end else if (burst_cnt == '0) begin
      mode_q <= mode_t'(mode);
      if (mode == MODE_FIX_B) begin
        state <= SEND_B;
      end else if (mode == MODE_FIX_C) begin
        state <= SEND_C;
      end
    end
  end

endmodule

// File: doc/demux2_scheduler.md
Name: demux2_scheduler

Overview:
- Sequencing controller for the 2-way demultiplexer datapath. Select=0 routes to output B; Select=1 routes to output C.
- Accepts a WIDTH-bit input stream with a valid/ready handshake and holds each word in a one-deep output register.
- Drives the demux Select and steers words to outB or outC in bursts of BURST_LEN, honouring per-output backpressure.
- Sits between the upstream producer and the two downstream consumers.

Parameters:
- WIDTH, 2, data word width.
- BURST_LEN, 4, words sent to one output before switching (>=1).
- CNT_W, 3, burst counter width; must satisfy 2**CNT_W > BURST_LEN.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- A_in  in  WIDTH  input data word.
- in_valid  in  1  A_in valid.
- in_ready  out  1  block can accept A_in this cycle.
- mode  in  2  00 alternate bursts B/C; 01 fixed B; 10 fixed C; 11 alternate with skip-if-busy.
- Select  out  1  demux select for the word currently held (0=B, 1=C).
- outB  out  WIDTH  data to output B.
- outB_valid  out  1  outB holds a valid word.
- outB_ready  in  1  consumer B accepts.
- outC  out  WIDTH  data to output C.
- outC_valid  out  1  outC holds a valid word.
- outC_ready  in  1  consumer C accepts.
- burst_cnt  out  CNT_W  words accepted in the current burst.

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values: data_q=0, valid_q=0, Select=0, state=SEND_B, burst_cnt=0, mode_q=00. All outputs are 0 during reset, including in_ready.
- Holding register (data_q, valid_q, sel_q):
  - outB = sel_q ? 0 : data_q.
  - outC = sel_q ? data_q : 0.
  - outB_valid = valid_q & ~sel_q.
  - outC_valid = valid_q & sel_q.
  - Select = sel_q.
- drain = (outB_valid & outB_ready) | (outC_valid & outC_ready).
- in_ready = ~rst & (~valid_q | drain). Pass-through at full rate is required.
- accept = in_valid & in_ready. On accept: data_q<=A_in, valid_q<=1, sel_q<=target, where target = (state==SEND_C).
  - Else if drain: valid_q<=0.
  - Latency: A_in to outB/outC is 1 cycle.
- Outputs stay stable while valid & ~ready: data_q and sel_q are not modified.
- FSM states: SEND_B, SEND_C. burst_cnt increments on accept.
- On accept with burst_cnt==BURST_LEN-1 (burst boundary): burst_cnt<=0 and the next state is chosen by mode_q:
  - 00: toggle state.
  - 01: SEND_B.
  - 10: SEND_C.
  - 11: toggle, unless the other output's ready is 0 and the current output's ready is 1 in that cycle; then stay.
- mode is sampled into mode_q only when burst_cnt==0 and no accept occurs that cycle. A mode change never splits a burst.
  - On that sample, 01 forces state SEND_B and 10 forces SEND_C immediately.
  - 00 and 11 keep the current state.
- BURST_LEN==1: every accept is a boundary.
- burst_cnt never exceeds BURST_LEN-1. There is no wrap beyond that.
- Simultaneous accept and drain: the new word overwrites, valid_q stays 1, and no bubble is inserted.
- Reset mid-burst: the held word is discarded, the counter clears and the state returns to SEND_B asynchronously.
- After reset release, in_ready=1 on the first clock.

Decomposition:
- Shared package holds:
  - the mode encodings MODE_ALT=2'b00, MODE_FIX_B=2'b01, MODE_FIX_C=2'b10, MODE_SKIP=2'b11;
  - the state encodings SEND_B=1'b0, SEND_C=1'b1.
- One sub-module is natural: demux2_hold_reg (one-deep data/valid/sel register with the drain logic).
- The existing DeMultiplexer2ver is instantiated at the top level, fed by data_q and Select, to produce outB/outC. Gating by valid_q stays in the scheduler.

Test Plan:
- Reset then mode=00, BURST_LEN=4, both readies=1, stream A_in=0,1,2,3,0,1,2,3 one word per cycle -> first four words on outB, next four on outC, each 1 cycle after accept. Select reads 0,0,0,0,1,1,1,1 and burst_cnt cycles 1,2,3,0.
- Backpressure: outB_ready=0 for 3 cycles with word 2'b10 held -> outB=2'b10 and outB_valid=1 stable, in_ready=0. When outB_ready returns to 1, the same-cycle accept of the next word gives no bubble.
- Mode change mid-burst: after 2 words in mode 00, set mode=10 -> the remaining 2 words of the burst still go to B. Then all words go to C. mode_q updates only at burst_cnt==0 with no accept.
- Skip mode 11: at a B burst boundary with outC_ready=0 and outB_ready=1 -> the next burst stays on B (Select=0). With outC_ready=1 it switches to C.
- Async reset asserted mid-burst (burst_cnt=2, valid_q=1) -> outputs are immediately 0, in_ready=0. After release, the next word goes to B with burst_cnt=1.
- Fixed mode 01 with outC_ready toggling randomly -> outC_valid never asserts and all words appear on outB in order.
